// File: rtl/param_pkg.sv
// param_pkg: shared constants, types and helpers for the parameter loader
package param_pkg;
  localparam int PARSIZE = 16;
  localparam int WORD_W = 9 * PARSIZE;
  localparam int WIDE_BYTES = WORD_W / 8;
  localparam int NARROW_BYTES = PARSIZE / 8;
  localparam int CONV_W_DEPTH = 2576;
  localparam int CONV_B_DEPTH = 112;
  localparam int DENSE_W_DEPTH = 33792;
  localparam int DENSE_B_DEPTH = 192;
  localparam logic [15:0] CONV1_BASE = 16'd0;
  localparam logic [15:0] CONV2_BASE = 16'd16;
  localparam logic [15:0] CONV3_BASE = 16'd528;
  localparam logic [15:0] DENSE2_BASE = 16'd0;
  localparam logic [15:0] DENSE1_BASE = 16'd24576;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_REGION = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  typedef enum logic [1:0] {REG_CONV_W = 2'd0, REG_CONV_B = 2'd1, REG_DENSE_W = 2'd2, REG_DENSE_B = 2'd3} region_t;
  typedef enum logic [2:0] {IDLE, ST_LO, ST_HI, CN_LO, CN_HI, DATA, WRITE} state_t;
  function automatic logic [16:0] depth_of(region_t r);
    return r == REG_CONV_W ? 17'(CONV_W_DEPTH) :
           r == REG_CONV_B ? 17'(CONV_B_DEPTH) :
           r == REG_DENSE_W ? 17'(DENSE_W_DEPTH) : 17'(DENSE_B_DEPTH);
  endfunction
endpackage

// File: rtl/param_loader_if.sv
// param_loader_if: byte stream in and memory write port out of the parameter loader
interface param_loader_if;
  import param_pkg::*;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [3:0] wr_en;
  logic [15:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  modport master (output in_data, in_valid, input in_ready, wr_en, wr_addr, wr_data);
  modport slave (input in_data, in_valid, output in_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/param_word_asm.sv
// param_word_asm: little-endian byte-to-word assembler for 2- or 18-byte words
module param_word_asm
  import param_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wide,
  input  logic              fire,
  input  logic [7:0]        din,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);
  logic [WORD_W-1:0] sreg;
  logic [4:0] cnt;
  assign word_ready = fire && cnt == (wide ? 5'(WIDE_BYTES - 1) : 5'(NARROW_BYTES - 1));
  always_comb begin
    word = sreg;
    word[{cnt, 3'b000} +: 8] = din;
  end
  always_ff @(posedge clk) begin
    if (rst || clr || word_ready) begin
      sreg <= '0;
      cnt <= '0;
    end else if (fire) begin
      sreg[{cnt, 3'b000} +: 8] <= din;
      cnt <= cnt + 5'd1;
    end
  end
endmodule

// File: rtl/param_loader.sv
// param_loader: frames a byte stream into load packets and writes the parameter memories
module param_loader
  import param_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  param_loader_if.slave       bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code
);
  state_t state, state_n;
  region_t region;
  logic [15:0] start, addr, remain, count_in;
  logic [7:0] cnt_lo;
  logic fire, wr_go, ovf, bad_region;
  logic [WORD_W-1:0] word;
  assign bus.in_ready = state != WRITE;
  assign fire = bus.in_valid && bus.in_ready;
  assign count_in = {bus.in_data, cnt_lo};
  assign ovf = {1'b0, start} + {1'b0, count_in} > depth_of(region);
  assign bad_region = bus.in_data > 8'd3;
  assign busy = state != IDLE || done || err;
  param_word_asm u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == IDLE),
    .wide      (region == REG_CONV_W),
    .fire      (fire && state == DATA),
    .din       (bus.in_data),
    .word      (word),
    .word_ready(wr_go)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = fire && !bad_region ? ST_LO : IDLE;
      ST_LO: state_n = fire ? ST_HI : ST_LO;
      ST_HI: state_n = fire ? CN_LO : ST_HI;
      CN_LO: state_n = fire ? CN_HI : CN_LO;
      CN_HI: state_n = !fire ? CN_HI : (ovf || count_in == 16'd0) ? IDLE : DATA;
      DATA:  state_n = wr_go ? WRITE : DATA;
      WRITE: state_n = remain == 16'd1 ? IDLE : DATA;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      region <= REG_CONV_W;
      start <= '0;
      cnt_lo <= '0;
      addr <= '0;
      remain <= '0;
      done <= 1'b0;
      err <= 1'b0;
      err_code <= ERR_NONE;
      bus.wr_en <= '0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      done <= (state == WRITE && remain == 16'd1) || (state == CN_HI && fire && !ovf && count_in == 16'd0);
      err <= fire && ((state == IDLE && bad_region) || (state == CN_HI && ovf));
      if (fire && state == IDLE && bad_region) err_code <= ERR_REGION;
      else if (fire && state == CN_HI && ovf) err_code <= ERR_RANGE;
      bus.wr_en <= wr_go ? 4'd1 << region : 4'd0;
      if (wr_go) begin
        bus.wr_addr <= addr;
        bus.wr_data <= word;
      end
      if (fire && state == IDLE) region <= region_t'(bus.in_data[1:0]);
      if (fire && state == ST_LO) start[7:0] <= bus.in_data;
      if (fire && state == ST_HI) start[15:8] <= bus.in_data;
      if (fire && state == CN_LO) cnt_lo <= bus.in_data;
      if (fire && state == CN_HI) begin
        addr <= start;
        remain <= count_in;
      end
      if (state == WRITE) begin
        addr <= addr + 16'd1;
        remain <= remain - 16'd1;
      end
    end
  end
endmodule
